// File: rtl/dispatch_1_to_6.sv
// dispatch_1_to_6: registered 1-to-N_OUT result distributor.
//
// One word per cycle arrives over a valid/ready handshake, tagged with a
// destination lane index. Each lane has a one-deep buffer that holds its word
// until that lane's consumer takes it. Words addressed to a lane index that
// does not exist are accepted, dropped, flagged for one cycle and counted.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   in_valid     producer presents a word
//   in_ready     block can take the presented word this cycle
//   in_data      word to distribute
//   in_sel       destination lane index
//   out_valid    bit i: lane i buffer holds a word
//   out_ready    bit i: lane i consumer takes its word this cycle
//   out_data     lane i at bits [i*DATA_W +: DATA_W]
//   illegal_sel  one-cycle pulse after an out-of-range word was dropped
//   drop_cnt     saturating count of dropped words
module dispatch_1_to_6 #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned N_OUT  = 6,
  parameter int unsigned SEL_W  = 3,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [SEL_W-1:0]        in_sel,
  output logic [N_OUT-1:0]        out_valid,
  input  logic [N_OUT-1:0]        out_ready,
  output logic [N_OUT*DATA_W-1:0] out_data,
  output logic                    illegal_sel,
  output logic [CNT_W-1:0]        drop_cnt
);

  localparam logic [SEL_W:0] NOutW = N_OUT[SEL_W:0];

  logic [N_OUT-1:0]             full_q, full_d;
  logic [N_OUT-1:0][DATA_W-1:0] data_q, data_d;
  logic                         illegal_q, illegal_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;

  logic             sel_legal;
  logic [N_OUT-1:0] sel_oh;
  logic             accept;

  // One-hot lane decode; all-zero when in_sel addresses no lane.
  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < N_OUT; i++) begin
      sel_oh[i] = (in_sel == SEL_W'(i));
    end
  end

  assign sel_legal = ({1'b0, in_sel} < NOutW);

  // A full lane can still accept when its consumer drains in the same cycle,
  // so out_ready feeds in_ready combinationally. Illegal selects always accept.
  assign in_ready = !sel_legal || (|(sel_oh & (~full_q | out_ready)));
  assign accept   = in_valid && in_ready;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    for (int i = 0; i < N_OUT; i++) begin
      if (accept && sel_oh[i]) begin
        full_d[i] = 1'b1;
        data_d[i] = in_data;
      end else if (full_q[i] && out_ready[i]) begin
        full_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    illegal_d = accept && !sel_legal;
    cnt_d     = cnt_q;
    if (illegal_d && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q    <= '0;
      data_q    <= '0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      full_q    <= full_d;
      data_q    <= data_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  assign out_valid   = full_q;
  assign out_data    = data_q;
  assign illegal_sel = illegal_q;
  assign drop_cnt    = cnt_q;

endmodule

// File: doc/dispatch_1_to_6.md
Name: dispatch_1_to_6

Overview:
- Registered 1-to-6 result distributor for the 16-bit datapath; the write-side counterpart of the 6-input source select.
- Accepts one word per cycle, tagged with a 3-bit destination select, over a valid/ready handshake.
- Holds each word in a one-deep buffer for its destination lane until that lane's consumer takes it.
- Sits between producers (ALU, memory read, PC adder) and consumers (register file write port, pipeline registers), decoupling their stalls.

Parameters:
- DATA_W, 16, width of every data word.
- N_OUT, 6, number of destination lanes; must satisfy N_OUT <= 2^SEL_W.
- SEL_W, 3, width of the destination select.
- CNT_W, 8, width of the saturating illegal-select drop counter.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  producer presents a word.
- in_ready  output  1  block can take the presented word this cycle.
- in_data  input  DATA_W  word to distribute.
- in_sel  input  SEL_W  destination lane index.
- out_valid  output  N_OUT  bit i: lane i buffer holds a word.
- out_ready  input  N_OUT  bit i: lane i consumer takes its word this cycle.
- out_data  output  N_OUT*DATA_W  lane i occupies bits [i*DATA_W +: DATA_W].
- illegal_sel  output  1  one-cycle registered pulse: a word with in_sel >= N_OUT was accepted and dropped.
- drop_cnt  output  CNT_W  saturating count of dropped words.

Behaviour:
- Reset (async assert, sync release): out_valid = 0, every out_data lane = 0, illegal_sel = 0, drop_cnt = 0. Reset mid-transfer discards all buffered words; no output activity occurs until the first edge after release.
- Per lane i: full_i flag (drives out_valid[i]) and data register (drives lane i of out_data).
- Handshake terms:
  - Accept = in_valid & in_ready.
  - Lane i drain = out_valid[i] & out_ready[i].
- in_ready:
  - in_sel < N_OUT: in_ready = !full[in_sel] | out_ready[in_sel].
  - in_sel >= N_OUT: in_ready = 1.
  - in_ready is independent of in_valid. A combinational path out_ready -> in_ready is permitted and intended.
- Lane update at each edge:
  - Accept to lane i, no drain: full_i <- 1, data_i <- in_data.
  - Drain of lane i, no accept to lane i: full_i <- 0, data_i holds.
  - Accept and drain on lane i in the same cycle: data_i <- in_data, full_i stays 1. Back-to-back throughput is one word per cycle per lane.
  - Neither: hold.
- Latency: a word accepted at edge N appears on out_valid/out_data after edge N (visible in cycle N+1); one cycle, no bypass.
- Stability: while out_valid[i] = 1 and out_ready[i] = 0, lane i data is held constant.
- Empty lanes: out_data holds the last delivered word (0 after reset); consumers must qualify with out_valid.
- Independence: lanes drain independently; any subset of out_ready may be high in one cycle. At most one lane fills per cycle.
- Illegal select (accepted word with in_sel >= N_OUT):
  - The word is dropped and no lane changes.
  - illegal_sel = 1 for exactly the next cycle.
  - drop_cnt increments, saturating at 2^CNT_W - 1 (255) with no wrap.
- in_data and in_sel are don't-care when in_valid = 0.
- No state changes without a handshake.

Test Plan:
- Reset then idle: out_valid = 6'b000000, all out_data = 0, drop_cnt = 0, in_ready = 1 for every in_sel value.
- Fill and backpressure: send 0x1234 to lane 2 with out_ready = 0. Cycle later: out_valid = 6'b000100, lane 2 = 0x1234. Then present 0xBEEF to lane 2: in_ready = 0 and lane 2 stays 0x1234 for 5 cycles. Raise out_ready[2]: 0xBEEF is accepted that same cycle and out_valid[2] remains 1 with lane 2 = 0xBEEF.
- Streaming: out_ready = all ones, send 0x0001..0x0006 to lanes 0..5 on consecutive cycles. Each lane's out_valid is high for exactly one cycle, one cycle after acceptance, with the matching value; in_ready is never low.
- Illegal select: send 0xDEAD with in_sel = 6, then in_sel = 7. illegal_sel pulses twice, drop_cnt = 2, out_valid unchanged. Continue for 300 illegal words: drop_cnt saturates at 255.
- Simultaneous: lanes 0 and 5 full; in one cycle raise out_ready = 6'b100001 and accept 0x00AA to lane 3. Next cycle out_valid = 6'b001000.
- Async reset mid-operation: with lanes 1 and 4 full, pulse rst_n low between edges. out_valid clears immediately without a clock edge, and drop_cnt = 0.
